// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with burst-limited fairness onto a shared read/write bus.
// Grants are combinational from owner/burst state; read-valid is returned one cycle later.
module bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m0_wdata,
  input  logic [15:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [15:0] m0_rdata,
  output logic [15:0] m1_rdata,
  output logic [15:0] read_addr,
  input  logic [15:0] read_data,
  output logic [15:0] write_addr,
  output logic [15:0] write_data,
  output logic        write_strobe
);

  localparam logic [0:0] OWNER_M0 = 1'b0;
  localparam logic [0:0] OWNER_M1 = 1'b1;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [0:0] owner;
  logic [3:0] burst_cnt;
  logic       any_gnt;
  logic [0:0] granted;

  // Contention hands the bus to the non-owner only once the owner's burst is exhausted.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!i_rst) begin
      if (m0_req && m1_req) begin
        if (burst_cnt < BURST_MAX) begin
          m0_gnt = (owner == OWNER_M0);
          m1_gnt = (owner == OWNER_M1);
        end else begin
          m0_gnt = (owner == OWNER_M1);
          m1_gnt = (owner == OWNER_M0);
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;
  assign granted = m1_gnt ? OWNER_M1 : OWNER_M0;

  always_comb begin
    read_addr  = '0;
    write_addr = '0;
    write_data = '0;
    if (m0_gnt) begin
      read_addr  = m0_addr;
      write_addr = m0_addr;
      write_data = m0_wdata;
    end else if (m1_gnt) begin
      read_addr  = m1_addr;
      write_addr = m1_addr;
      write_data = m1_wdata;
    end
  end

  assign write_strobe = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign m0_rdata     = read_data;
  assign m1_rdata     = read_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner     <= OWNER_M0;
      burst_cnt <= '0;
    end else if (!any_gnt) begin
      burst_cnt <= '0;
    end else if (granted == owner) begin
      if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
    end else begin
      owner     <= granted;
      burst_cnt <= 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario-task bench for bus_arbiter: directed cases plus randomized traffic
// compared against a run-length fairness model.
module tb_bus_arbiter;

  localparam int MB = 4;

  logic        i_clk, i_rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata, read_data;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, write_strobe;
  logic [15:0] m0_rdata, m1_rdata, read_addr, write_addr, write_data;

  int checks = 0;
  int failures = 0;

  // Reference model: last granted master and length of its current run of grants.
  int   m_owner;
  int   m_streak;
  logic exp_rv0, exp_rv1;

  bus_arbiter #(.MAX_BURST(MB)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_strobe(write_strobe)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                       input logic [15:0] rd);
    @(negedge i_clk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    read_data = rd;
    #2;
  endtask

  task automatic do_reset;
    @(negedge i_clk);
    i_rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; read_data = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    m_owner = 0; m_streak = 0; exp_rv0 = 0; exp_rv1 = 0;
  endtask

  task automatic test_reset;
    @(negedge i_clk);
    i_rst = 1'b1; m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    m0_addr = 16'h1234; m1_addr = 16'h5678;
    #2;
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if (write_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", write_strobe); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
    checks++; if (read_addr !== 16'h0) begin failures++; $display("FAIL reset_read_addr got=%h exp=0000", read_addr); end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0; m0_we = 0; m1_we = 0;
    #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL reset_release_m0_first got=%b exp=10", {m0_gnt, m1_gnt}); end
  endtask

  task automatic test_single_read;
    do_reset();
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL single_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
    checks++; if (read_addr !== 16'h0010) begin failures++; $display("FAIL single_read_addr got=%h exp=0010", read_addr); end
    checks++; if (write_strobe !== 1'b0) begin failures++; $display("FAIL single_strobe got=%b exp=0", write_strobe); end
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'hBEEF);
    checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL single_rvalid got=%b exp=1", m0_rvalid); end
    checks++; if (m0_rdata !== 16'hBEEF) begin failures++; $display("FAIL single_rdata got=%h exp=beef", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL single_m1_rvalid got=%b exp=0", m1_rvalid); end
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL single_rvalid_one_cycle got=%b exp=0", m0_rvalid); end
  endtask

  task automatic test_write;
    do_reset();
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h8101, 16'h00A5, 16'h0);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin failures++; $display("FAIL write_gnt got=%b exp=01", {m0_gnt, m1_gnt}); end
    checks++; if (write_strobe !== 1'b1) begin failures++; $display("FAIL write_strobe got=%b exp=1", write_strobe); end
    checks++; if (write_addr !== 16'h8101) begin failures++; $display("FAIL write_addr got=%h exp=8101", write_addr); end
    checks++; if (write_data !== 16'h00A5) begin failures++; $display("FAIL write_data got=%h exp=00a5", write_data); end
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL write_no_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
  endtask

  task automatic test_contention;
    int pat[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 16'h0A00 + 16'(i), 16'h0, 1, 0, 16'h0B00 + 16'(i), 16'h0, 16'h0);
      checks++;
      if ({m0_gnt, m1_gnt} !== ((pat[i] == 1) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL contention_cycle%0d got=%b exp_master=%0d", i, {m0_gnt, m1_gnt}, pat[i]);
      end
    end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 16'h0100, 16'h0, 0, 0, 16'h0200, 16'h0, 16'h0);
      checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL sat_m0_alone%0d got=%b exp=1", i, m0_gnt); end
    end
    drive(1, 0, 16'h0100, 16'h0, 1, 0, 16'h0200, 16'h0, 16'h0);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin failures++; $display("FAIL sat_switch got=%b exp=01", {m0_gnt, m1_gnt}); end
    checks++; if (read_addr !== 16'h0200) begin failures++; $display("FAIL sat_read_addr got=%h exp=0200", read_addr); end
  endtask

  task automatic test_idle_gap;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 16'h0300, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
      checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL gap_pre%0d got=%b exp=1", i, m0_gnt); end
    end
    drive(0, 1, 16'hDEAD, 16'hCAFE, 0, 1, 16'hF00D, 16'h1111, 16'h0);
    checks++; if ({m0_gnt, m1_gnt, write_strobe} !== 3'b000) begin failures++; $display("FAIL gap_idle_gnt got=%b exp=000", {m0_gnt, m1_gnt, write_strobe}); end
    checks++; if ({read_addr, write_addr, write_data} !== 48'h0) begin failures++; $display("FAIL gap_idle_bus got=%h exp=0", {read_addr, write_addr, write_data}); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 16'h0300, 16'h0, 1, 0, 16'h0400, 16'h0, 16'h0);
      checks++;
      if ({m0_gnt, m1_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL gap_both%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, (i < 4) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0555, 16'h0, 16'h0);
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got=%b exp=1", m1_gnt); end
    @(negedge i_clk);
    #1;
    checks++; if (m1_rvalid !== 1'b1) begin failures++; $display("FAIL rstmid_rvalid_pre got=%b exp=1", m1_rvalid); end
    i_rst = 1'b1; m0_req = 1;
    #1;
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid_drop got=%b exp=0", m1_rvalid); end
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin failures++; $display("FAIL rstmid_gnt got=%b exp=00", {m0_gnt, m1_gnt}); end
    @(negedge i_clk);
    i_rst = 1'b0;
    #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL rstmid_release got=%b exp=10", {m0_gnt, m1_gnt}); end
  endtask

  task automatic test_back_to_back;
    int seq[6] = '{0, 1, 0, 1, 1, 0};
    int prev = -1;
    logic [15:0] rd;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rd = 16'($urandom);
      drive(seq[i] == 0, 0, 16'h1000 + 16'(i), 16'h0, seq[i] == 1, 0, 16'h2000 + 16'(i), 16'h0, rd);
      checks++;
      if ({m0_gnt, m1_gnt} !== ((seq[i] == 1) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL b2b_gnt%0d got=%b", i, {m0_gnt, m1_gnt});
      end
      checks++;
      if (read_addr !== ((seq[i] == 1) ? 16'h2000 : 16'h1000) + 16'(i)) begin
        failures++; $display("FAIL b2b_addr%0d got=%h", i, read_addr);
      end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== {prev == 0, prev == 1}) begin
        failures++; $display("FAIL b2b_rvalid%0d got=%b exp=%b", i, {m0_rvalid, m1_rvalid}, {prev == 0, prev == 1});
      end
      checks++; if (m1_rdata !== rd) begin failures++; $display("FAIL b2b_rdata%0d got=%h exp=%h", i, m1_rdata, rd); end
      prev = seq[i];
    end
  endtask

  task automatic test_random;
    logic r0, r1, w0, w1;
    logic [15:0] a0, a1, d0, d1, rd, e_addr, e_wdata;
    int pick;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r0 = 1'($urandom_range(0, 3) != 0); r1 = 1'($urandom_range(0, 3) != 0);
      w0 = 1'($urandom); w1 = 1'($urandom);
      a0 = 16'($urandom); a1 = 16'($urandom); d0 = 16'($urandom); d1 = 16'($urandom);
      rd = 16'($urandom);
      drive(r0, w0, a0, d0, r1, w1, a1, d1, rd);
      checks++;
      if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin
        failures++; $display("FAIL rand_rvalid%0d got=%b exp=%b", i, {m0_rvalid, m1_rvalid}, {exp_rv0, exp_rv1});
      end
      if (r0 && r1) pick = (m_streak >= MB) ? 1 - m_owner : m_owner;
      else if (r0) pick = 0;
      else if (r1) pick = 1;
      else pick = -1;
      checks++;
      if ({m0_gnt, m1_gnt} !== {pick == 0, pick == 1}) begin
        failures++; $display("FAIL rand_gnt%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, {pick == 0, pick == 1});
      end
      e_addr  = (pick == 0) ? a0 : (pick == 1) ? a1 : 16'h0;
      e_wdata = (pick == 0) ? d0 : (pick == 1) ? d1 : 16'h0;
      checks++;
      if ({read_addr, write_addr, write_data} !== {e_addr, e_addr, e_wdata}) begin
        failures++; $display("FAIL rand_bus%0d got=%h/%h/%h exp=%h/%h/%h", i, read_addr, write_addr, write_data, e_addr, e_addr, e_wdata);
      end
      checks++;
      if (write_strobe !== ((pick == 0 && w0) || (pick == 1 && w1))) begin
        failures++; $display("FAIL rand_strobe%0d got=%b", i, write_strobe);
      end
      checks++;
      if (m0_rdata !== rd || m1_rdata !== rd) begin
        failures++; $display("FAIL rand_rdata%0d got=%h/%h exp=%h", i, m0_rdata, m1_rdata, rd);
      end
      if (pick < 0) m_streak = 0;
      else if (pick == m_owner) m_streak++;
      else begin m_owner = pick; m_streak = 1; end
      exp_rv0 = (pick == 0) && !w0;
      exp_rv1 = (pick == 1) && !w1;
    end
  endtask

  initial begin
    i_rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; read_data = '0;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_saturation();
    test_idle_gap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
